// File: rtl/trap_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trap_controller_pkg
// Description : Shared constants for the trap controller:
//               - exception codes (NO_E marks "no exception")
//               - region bases and the reset vector
//               - drain length and its counter width
//               - TC_S_* state encodings
//               - helpers for code validity and vector address formation
// Revision    : 1.0 - initial release
// ============================================================================
package trap_controller_pkg;

  // Exception codes carried by the fetch and execute stages
  localparam logic [3:0] NO_E                    = 4'hF;
  localparam logic [3:0] E_INSTR_ADDR_MISALIGNED = 4'h0;
  localparam logic [3:0] E_INSTR_ACCESS_FAULT    = 4'h1;
  localparam logic [3:0] E_ILLEGAL_INSTR         = 4'h2;
  localparam logic [3:0] E_BREAKPOINT            = 4'h3;
  localparam logic [3:0] E_LOAD_ADDR_MISALIGNED  = 4'h4;
  localparam logic [3:0] E_LOAD_ACCESS_FAULT     = 4'h5;
  localparam logic [3:0] E_STORE_ADDR_MISALIGNED = 4'h6;
  localparam logic [3:0] E_STORE_ADDR_FAULT      = 4'h7;
  localparam logic [3:0] E_ECALL                 = 4'hB;

  // Memory regions, selected by pc[20:18]
  localparam logic [31:0] TRAP_BASE    = 32'h0000_0000;
  localparam logic [31:0] TEXT_BASE    = 32'h0008_0000;
  localparam logic [31:0] RESET_VECTOR = 32'h0004_0000;

  // Cycles the older D/E instructions need to retire ahead of a faulting fetch
  localparam int DRAIN_CYC = 2;
  localparam int DRAIN_W   = $clog2(DRAIN_CYC + 1);

  // Controller state encodings
  typedef logic [2:0] tc_state_t;
  localparam tc_state_t TC_S_RESET = 3'd0;
  localparam tc_state_t TC_S_RUN   = 3'd1;
  localparam tc_state_t TC_S_DRAIN = 3'd2;
  localparam tc_state_t TC_S_TRAP  = 3'd3;
  localparam tc_state_t TC_S_HALT  = 3'd4;

  function automatic logic code_valid(input logic [3:0] code);
    return code != NO_E;
  endfunction

  // Vectored entry: one word per cause inside the trap region
  function automatic logic [31:0] trap_vector(input logic [3:0] cause);
    return TRAP_BASE + {26'd0, cause, 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/trap_drain_counter.sv
`default_nettype none
// ============================================================================
// Module      : trap_drain_counter
// Description : Load / decrement counter timing the pipeline drain that
//               precedes a fetch-stage trap.
// Ports       : i_clk       clock, rising edge
//               i_rst       asynchronous active-high reset
//               i_load      load i_load_val (has priority over i_dec)
//               i_load_val  drain length
//               i_dec       decrement by one (saturates at zero)
//               o_expire    current cycle is the last drain cycle; the
//                           decrement taken this edge reaches zero
// Revision    : 1.0 - initial release
// ============================================================================
module trap_drain_counter #(
  parameter int WIDTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_expire
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  // Looking one step ahead lets the trap be taken on the same edge the
  // count hits zero, so the redirect lands right after the last drain cycle.
  assign o_expire = (r_count <= WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/trap_controller.sv
`default_nettype none
// ============================================================================
// Module      : trap_controller
// Description : Trap entry/exit sequencer for the five-stage RV32 pipeline.
//               Orders fetch/execute exceptions by age, drains the pipeline
//               for fetch faults, redirects into the vectored trap region,
//               latches mepc/mcause and drives region permission flags.
//               Flush/stall outputs are OR-ed with the hazard unit's.
// Ports       : i_clk, i_rst             clock / async active-high reset
//               i_exception_code_f/_e    stage exception codes (NO_E = none)
//               i_pc_f, i_pc_e           stage PCs
//               i_branch_taken_e         execute redirect, younger = wrong path
//               i_mret_e                 return instruction in execute
//               o_reset_permission       executing reset-vector code
//               o_trap_permission        executing trap-handler code
//               o_stall_f                hold PC / IF register
//               o_flush_d, o_flush_e     bubble into D / E
//               o_redirect, o_redirect_pc one-cycle PC load and its value
//               o_mepc, o_mcause         saved trap PC and cause
//               o_halt                   double fault, core frozen
//               o_trap_count             trap entries, saturating
//                                        (only with TRAP_COUNTER_EN)
// Options     : TRAP_COUNTER_EN - adds the saturating trap entry counter
// Revision    : 1.0 - initial release
// ============================================================================
module trap_controller
  import trap_controller_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [3:0]  i_exception_code_f,
  input  logic [3:0]  i_exception_code_e,
  input  logic [31:0] i_pc_f,
  input  logic [31:0] i_pc_e,
  input  logic        i_branch_taken_e,
  input  logic        i_mret_e,
  output logic        o_reset_permission,
  output logic        o_trap_permission,
  output logic        o_stall_f,
  output logic        o_flush_d,
  output logic        o_flush_e,
  output logic        o_redirect,
  output logic [31:0] o_redirect_pc,
  output logic [31:0] o_mepc,
  output logic [3:0]  o_mcause,
  output logic        o_halt
`ifdef TRAP_COUNTER_EN
  ,
  output logic [15:0] o_trap_count
`endif
);

  tc_state_t   r_state;
  tc_state_t   w_next_state;

  // Transition qualifiers from the next-state process
  logic        w_e_trap;
  logic        w_f_trap;
  logic        w_drain_start;
  logic        w_drain_abort;
  logic        w_mret_exit;
  logic        w_reset_exit;
  logic        w_drain_expire;

  logic        w_e_valid;
  logic        w_f_valid;

  // Pending fetch fault held across the drain
  logic [31:0] r_pend_pc;
  logic [3:0]  r_pend_code;

  // Registered outputs and their next values
  logic        r_reset_perm,  w_reset_perm_nx;
  logic        r_trap_perm,   w_trap_perm_nx;
  logic        r_stall_f,     w_stall_f_nx;
  logic        r_flush_d,     w_flush_d_nx;
  logic        r_flush_e,     w_flush_e_nx;
  logic        r_redirect,    w_redirect_nx;
  logic [31:0] r_redirect_pc, w_redirect_pc_nx;
  logic [31:0] r_mepc,        w_mepc_nx;
  logic [3:0]  r_mcause,      w_mcause_nx;
  logic        r_halt,        w_halt_nx;

  assign w_e_valid = code_valid(i_exception_code_e);
  assign w_f_valid = code_valid(i_exception_code_f);

  trap_drain_counter #(
    .WIDTH (DRAIN_W)
  ) u_drain_counter (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_drain_start),
    .i_load_val (DRAIN_W'(DRAIN_CYC)),
    .i_dec      (r_state == TC_S_DRAIN),
    .o_expire   (w_drain_expire)
  );

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= TC_S_RESET;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. Execute codes always outrank fetch codes (older
  // instruction). A fetch code behind a taken branch is wrong-path and ignored.
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state  = r_state;
    w_e_trap      = 1'b0;
    w_f_trap      = 1'b0;
    w_drain_start = 1'b0;
    w_drain_abort = 1'b0;
    w_mret_exit   = 1'b0;
    w_reset_exit  = 1'b0;
    case (r_state)
      TC_S_RESET: begin
        if (w_e_valid || w_f_valid) begin
          w_next_state = TC_S_HALT;
        end else if (i_mret_e) begin
          w_next_state = TC_S_RUN;
          w_reset_exit = 1'b1;
        end
      end
      TC_S_RUN: begin
        if (w_e_valid) begin
          w_next_state = TC_S_TRAP;
          w_e_trap     = 1'b1;
        end else if (w_f_valid && !i_branch_taken_e) begin
          w_next_state  = TC_S_DRAIN;
          w_drain_start = 1'b1;
        end
      end
      TC_S_DRAIN: begin
        if (w_e_valid) begin
          w_next_state = TC_S_TRAP;
          w_e_trap     = 1'b1;
        end else if (i_branch_taken_e) begin
          // The faulting fetch turned out to be wrong-path
          w_next_state  = TC_S_RUN;
          w_drain_abort = 1'b1;
        end else if (w_drain_expire) begin
          w_next_state = TC_S_TRAP;
          w_f_trap     = 1'b1;
        end
      end
      TC_S_TRAP: begin
        // An E code alongside mret is a fault of the mret itself
        if (w_e_valid) begin
          w_next_state = TC_S_HALT;
        end else if (i_mret_e) begin
          w_next_state = TC_S_RUN;
          w_mret_exit  = 1'b1;
        end else if (w_f_valid && !i_branch_taken_e) begin
          w_next_state = TC_S_HALT;
        end
      end
      TC_S_HALT: begin
        w_next_state = TC_S_HALT;
      end
      default: begin
        w_next_state = TC_S_HALT;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic: next values of the registered outputs, plus the
  // combinational drain decode for stall_f / flush_d.
  // --------------------------------------------------------------------------
  always_comb begin
    w_halt_nx        = (w_next_state == TC_S_HALT);
    w_reset_perm_nx  = (w_next_state == TC_S_RESET);
    w_trap_perm_nx   = (w_next_state == TC_S_TRAP);
    w_redirect_nx    = w_e_trap | w_f_trap | w_mret_exit | w_reset_exit;
    w_flush_e_nx     = w_redirect_nx | w_halt_nx;
    w_flush_d_nx     = w_redirect_nx | w_drain_abort | w_halt_nx;
    w_stall_f_nx     = w_halt_nx;

    w_redirect_pc_nx = r_redirect_pc;
    w_mepc_nx        = r_mepc;
    w_mcause_nx      = r_mcause;

    if (w_e_trap) begin
      w_redirect_pc_nx = trap_vector(i_exception_code_e);
      w_mepc_nx        = i_pc_e;
      w_mcause_nx      = i_exception_code_e;
    end else if (w_f_trap) begin
      w_redirect_pc_nx = trap_vector(r_pend_code);
      w_mepc_nx        = r_pend_pc;
      w_mcause_nx      = r_pend_code;
    end else if (w_mret_exit) begin
      w_redirect_pc_nx = r_mepc + 32'd4;
    end else if (w_reset_exit) begin
      w_redirect_pc_nx = TEXT_BASE;
    end

    // Drain cycles hold fetch and bubble decode straight from the state
    o_stall_f = r_stall_f | (r_state == TC_S_DRAIN);
    o_flush_d = r_flush_d | (r_state == TC_S_DRAIN);
  end

  // --------------------------------------------------------------------------
  // Output and pending-fault registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_reset_perm  <= 1'b1;
      r_trap_perm   <= 1'b0;
      r_stall_f     <= 1'b0;
      r_flush_d     <= 1'b0;
      r_flush_e     <= 1'b0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= 32'd0;
      r_mepc        <= 32'd0;
      r_mcause      <= NO_E;
      r_halt        <= 1'b0;
      r_pend_pc     <= 32'd0;
      r_pend_code   <= NO_E;
    end else begin
      r_reset_perm  <= w_reset_perm_nx;
      r_trap_perm   <= w_trap_perm_nx;
      r_stall_f     <= w_stall_f_nx;
      r_flush_d     <= w_flush_d_nx;
      r_flush_e     <= w_flush_e_nx;
      r_redirect    <= w_redirect_nx;
      r_redirect_pc <= w_redirect_pc_nx;
      r_mepc        <= w_mepc_nx;
      r_mcause      <= w_mcause_nx;
      r_halt        <= w_halt_nx;
      if (w_drain_start) begin
        r_pend_pc   <= i_pc_f;
        r_pend_code <= i_exception_code_f;
      end
    end
  end

  assign o_reset_permission = r_reset_perm;
  assign o_trap_permission  = r_trap_perm;
  assign o_flush_e          = r_flush_e;
  assign o_redirect         = r_redirect;
  assign o_redirect_pc      = r_redirect_pc;
  assign o_mepc             = r_mepc;
  assign o_mcause           = r_mcause;
  assign o_halt             = r_halt;

`ifdef TRAP_COUNTER_EN
  // Counts entries into the trap handler only; double faults go to HALT
  logic [15:0] r_trap_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_trap_count <= 16'd0;
    end else if ((w_e_trap || w_f_trap) && (r_trap_count != 16'hFFFF)) begin
      r_trap_count <= r_trap_count + 16'd1;
    end
  end

  assign o_trap_count = r_trap_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_trap_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_trap_controller
// Description : Self-checking bench for trap_controller. Each expected
//               redirect is queued when its stimulus is issued; a monitor
//               pops and compares whenever the DUT raises o_redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trap_controller;
  import trap_controller_pkg::*;

  logic        clk;
  logic        rst;
  logic [3:0]  code_f, code_e;
  logic [31:0] pc_f, pc_e;
  logic        branch_taken, mret;
  logic        reset_perm, trap_perm, stall_f, flush_d, flush_e;
  logic        redirect, halt;
  logic [31:0] redirect_pc, mepc;
  logic [3:0]  mcause;
`ifdef TRAP_COUNTER_EN
  logic [15:0] trap_count;
`endif

  trap_controller dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_exception_code_f (code_f),
    .i_exception_code_e (code_e),
    .i_pc_f             (pc_f),
    .i_pc_e             (pc_e),
    .i_branch_taken_e   (branch_taken),
    .i_mret_e           (mret),
    .o_reset_permission (reset_perm),
    .o_trap_permission  (trap_perm),
    .o_stall_f          (stall_f),
    .o_flush_d          (flush_d),
    .o_flush_e          (flush_e),
    .o_redirect         (redirect),
    .o_redirect_pc      (redirect_pc),
    .o_mepc             (mepc),
    .o_mcause           (mcause),
    .o_halt             (halt)
`ifdef TRAP_COUNTER_EN
    ,
    .o_trap_count       (trap_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] mepc;
    logic [3:0]  mcause;
    logic        tperm;
    logic        rperm;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] p, input logic [31:0] m, input logic [3:0] c,
                      input logic tp, input logic rp);
    exp_t e;
    e.pc = p; e.mepc = m; e.mcause = c; e.tperm = tp; e.rperm = rp;
    sb.push_back(e);
  endtask

  // Monitor: every redirect pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst && redirect) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_redirect: got pc 0x%0h expected no redirect at %0t",
                 redirect_pc, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("mon_redirect_pc", redirect_pc, e.pc);
        chk("mon_mepc", mepc, e.mepc);
        chk("mon_mcause", {28'd0, mcause}, {28'd0, e.mcause});
        chk("mon_trap_perm", {31'd0, trap_perm}, {31'd0, e.tperm});
        chk("mon_reset_perm", {31'd0, reset_perm}, {31'd0, e.rperm});
      end
    end
  end

  // One stimulus cycle: inputs applied, sampled by the next edge, then idle
  task automatic drive(input logic [3:0] ce, input logic [31:0] pe,
                       input logic [3:0] cf, input logic [31:0] pf,
                       input logic br, input logic mr);
    code_e = ce; pc_e = pe; code_f = cf; pc_f = pf; branch_taken = br; mret = mr;
    @(posedge clk);
    #1;
    code_e = NO_E; pc_e = 32'd0; code_f = NO_E; pc_f = 32'd0;
    branch_taken = 1'b0; mret = 1'b0;
  endtask

  task automatic idle();
    drive(NO_E, 32'd0, NO_E, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_reset_perm"}, {31'd0, reset_perm}, 32'd1);
    chk({tag, "_trap_perm"}, {31'd0, trap_perm}, 32'd0);
    chk({tag, "_redirect"}, {31'd0, redirect}, 32'd0);
    chk({tag, "_redirect_pc"}, redirect_pc, 32'd0);
    chk({tag, "_mepc"}, mepc, 32'd0);
    chk({tag, "_mcause"}, {28'd0, mcause}, {28'd0, NO_E});
    chk({tag, "_halt"}, {31'd0, halt}, 32'd0);
    chk({tag, "_stall_f"}, {31'd0, stall_f}, 32'd0);
    chk({tag, "_flush_d"}, {31'd0, flush_d}, 32'd0);
    chk({tag, "_flush_e"}, {31'd0, flush_e}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    code_e = NO_E; pc_e = 32'd0; code_f = NO_E; pc_f = 32'd0;
    branch_taken = 1'b0; mret = 1'b0;
    #12;
    chk_reset_values("por");
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    chk("still_in_reset", {31'd0, reset_perm}, 32'd1);

    // Leave reset code via mret
    push(32'h0008_0000, 32'd0, NO_E, 1'b0, 1'b0);
    drive(NO_E, 32'h0004_0010, NO_E, 32'd0, 1'b0, 1'b1);
    chk("mret_reset_redirect", {31'd0, redirect}, 32'd1);
    chk("mret_reset_perm", {31'd0, reset_perm}, 32'd0);
    chk("mret_reset_flush_e", {31'd0, flush_e}, 32'd1);
    idle();
    chk("redirect_one_cycle", {31'd0, redirect}, 32'd0);
    chk("flush_d_one_cycle", {31'd0, flush_d}, 32'd0);

    // Execute-stage load access fault
    push(32'h0000_0014, 32'h0008_0024, E_LOAD_ACCESS_FAULT, 1'b1, 1'b0);
    drive(E_LOAD_ACCESS_FAULT, 32'h0008_0024, NO_E, 32'd0, 1'b0, 1'b0);
    chk("e_trap_redirect", {31'd0, redirect}, 32'd1);
    chk("e_trap_flush_d", {31'd0, flush_d}, 32'd1);
    idle();
    idle();
    chk("e_trap_perm_held", {31'd0, trap_perm}, 32'd1);
    push(32'h0008_0028, 32'h0008_0024, E_LOAD_ACCESS_FAULT, 1'b0, 1'b0);
    drive(NO_E, 32'h0000_0050, NO_E, 32'd0, 1'b0, 1'b1);
    chk("mret_trap_perm", {31'd0, trap_perm}, 32'd0);
    idle();

    // Fetch-stage illegal instruction: two drain cycles, then redirect
    push(32'h0000_0008, 32'h0008_0040, E_ILLEGAL_INSTR, 1'b1, 1'b0);
    drive(NO_E, 32'd0, E_ILLEGAL_INSTR, 32'h0008_0040, 1'b0, 1'b0);
    chk("drain1_stall_f", {31'd0, stall_f}, 32'd1);
    chk("drain1_flush_d", {31'd0, flush_d}, 32'd1);
    chk("drain1_redirect", {31'd0, redirect}, 32'd0);
    idle();
    chk("drain2_stall_f", {31'd0, stall_f}, 32'd1);
    chk("drain2_redirect", {31'd0, redirect}, 32'd0);
    idle();
    chk("f_trap_redirect", {31'd0, redirect}, 32'd1);
    chk("f_trap_stall_f", {31'd0, stall_f}, 32'd0);
    chk("f_trap_mepc", mepc, 32'h0008_0040);
    push(32'h0008_0044, 32'h0008_0040, E_ILLEGAL_INSTR, 1'b0, 1'b0);
    drive(NO_E, 32'd0, NO_E, 32'd0, 1'b0, 1'b1);
    idle();

    // Fetch fault overtaken by an older store fault in drain cycle 1
    push(32'h0000_001C, 32'h0008_0038, E_STORE_ADDR_FAULT, 1'b1, 1'b0);
    drive(NO_E, 32'd0, E_ILLEGAL_INSTR, 32'h0008_0040, 1'b0, 1'b0);
    drive(E_STORE_ADDR_FAULT, 32'h0008_0038, NO_E, 32'd0, 1'b0, 1'b0);
    chk("override_mcause", {28'd0, mcause}, {28'd0, E_STORE_ADDR_FAULT});
    chk("override_stall_f", {31'd0, stall_f}, 32'd0);
    push(32'h0008_003C, 32'h0008_0038, E_STORE_ADDR_FAULT, 1'b0, 1'b0);
    drive(NO_E, 32'd0, NO_E, 32'd0, 1'b0, 1'b1);
    idle();

    // Fetch fault cancelled by a taken branch during the drain
    drive(NO_E, 32'd0, E_INSTR_ACCESS_FAULT, 32'h0008_0050, 1'b0, 1'b0);
    drive(NO_E, 32'd0, NO_E, 32'd0, 1'b1, 1'b0);
    chk("abort_stall_f", {31'd0, stall_f}, 32'd0);
    chk("abort_flush_d", {31'd0, flush_d}, 32'd1);
    chk("abort_flush_e", {31'd0, flush_e}, 32'd0);
    chk("abort_mepc_held", mepc, 32'h0008_0038);
    idle();
    idle();
    chk("abort_trap_perm", {31'd0, trap_perm}, 32'd0);

    // Wrong-path fetch fault in RUN is discarded
    drive(NO_E, 32'd0, E_ILLEGAL_INSTR, 32'h0008_0060, 1'b1, 1'b0);
    chk("wrong_path_stall_f", {31'd0, stall_f}, 32'd0);
    idle();

    // Trap, then ecall inside the handler -> double fault
    push(32'h0000_0008, 32'h0008_0060, E_ILLEGAL_INSTR, 1'b1, 1'b0);
    drive(E_ILLEGAL_INSTR, 32'h0008_0060, NO_E, 32'd0, 1'b0, 1'b0);
    idle();
    drive(E_ECALL, 32'h0000_0100, NO_E, 32'd0, 1'b0, 1'b0);
    chk("halt_set", {31'd0, halt}, 32'd1);
    chk("halt_trap_perm", {31'd0, trap_perm}, 32'd0);
    chk("halt_stall_f", {31'd0, stall_f}, 32'd1);
    chk("halt_flush_e", {31'd0, flush_e}, 32'd1);
    chk("halt_mepc_held", mepc, 32'h0008_0060);
    drive(NO_E, 32'h0000_0104, NO_E, 32'd0, 1'b0, 1'b1);
    idle();
    chk("halt_sticky", {31'd0, halt}, 32'd1);
    chk("halt_flush_d", {31'd0, flush_d}, 32'd1);

    // Asynchronous reset mid-halt
    rst = 1'b1;
    #1;
    chk_reset_values("rst_halt");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Asynchronous reset mid-drain drops the pending cause
    push(32'h0008_0000, 32'd0, NO_E, 1'b0, 1'b0);
    drive(NO_E, 32'h0004_0020, NO_E, 32'd0, 1'b0, 1'b1);
    drive(NO_E, 32'd0, E_ILLEGAL_INSTR, 32'h0008_0070, 1'b0, 1'b0);
    chk("drain_before_rst", {31'd0, stall_f}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_drain_stall_f", {31'd0, stall_f}, 32'd0);
    chk("rst_drain_reset_perm", {31'd0, reset_perm}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    idle();
    idle();
    chk("post_rst_no_trap", {31'd0, trap_perm}, 32'd0);
    chk("post_rst_reset_perm", {31'd0, reset_perm}, 32'd1);

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/trap_controller.md
# trap_controller

Sequences trap entry and exit for the five-stage RV32 pipeline. It consumes the per-stage exception codes (fetch, execute), orders them by program age, and drains the pipeline when needed. It then redirects the PC into the vectored trap region and latches mepc/mcause, and drives the permission flags that the exception detector uses to police the reset, trap and text regions. It sits beside the hazard unit; its flush/stall outputs are OR-ed with the hazard unit's.

## Interface
- TRAP_BASE, 32'h0000_0000, trap vector region base (pc[20:18]=000)
- TEXT_BASE, 32'h0008_0000, text region base (pc[20:18]=010)
- DRAIN_CYC, 2, cycles needed for D/E to retire ahead of a faulting fetch
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset; one clock, asynchronous, active-high
- i_exception_code_f  in  4  fetch-stage code (`NO_E` = none)
- i_exception_code_e  in  4  execute-stage code
- i_pc_f  in  32  PC of fetch instruction
- i_pc_e  in  32  PC of execute instruction
- i_branch_taken_e  in  1  execute redirect (branch/jump); younger stages are wrong-path
- i_mret_e  in  1  return instruction in execute
- o_reset_permission  out  1  executing reset-vector code
- o_trap_permission  out  1  executing trap-handler code
- o_stall_f  out  1  hold PC/IF register
- o_flush_d, o_flush_e  out  1  bubble into D / E
- o_redirect  out  1  one-cycle PC load pulse
- o_redirect_pc  out  32  PC load value
- o_mepc  out  32  saved PC of trapping instruction
- o_mcause  out  4  saved exception code
- o_halt  out  1  double fault, core frozen

## Operation
- States: S_RESET, S_RUN, S_DRAIN, S_TRAP, S_HALT.
- S_RESET: reset_permission=1. PC register resets to reset vector 32'h0004_0000. i_mret_e → redirect to TEXT_BASE, flush D/E, → S_RUN.
- S_RUN:
  - A valid E code (≠`NO_E`) has priority. mepc←i_pc_e, mcause←code. Redirect to TRAP_BASE+{mcause,2'b00}. Flush D/E. → S_TRAP.
  - Otherwise, a valid F code with i_branch_taken_e=0: latch pc_f/code as pending, drain counter←DRAIN_CYC, → S_DRAIN.
  - F code with branch taken is discarded.
- S_DRAIN: stall_f=1, flush_d=1 each cycle; counter decrements.
  - E code → trap with E cause; the pending F code is dropped.
  - i_branch_taken_e → drop pending, flush D, → S_RUN.
  - Counter reaches 0 → trap with the pending cause and PC.
- S_TRAP: trap_permission=1.
  - i_mret_e → redirect to mepc+4 (32-bit wrap), flush D/E, → S_RUN.
  - Any valid E code, or a valid F code on a non-wrong-path fetch → S_HALT.
- S_RESET with any valid code → S_HALT.
- S_HALT: halt=1, stall_f=1, flush_d=flush_e=1 held. Exit only via i_rst.
- Same cycle, E code and i_mret_e: the exception wins (the E code is treated as a fault of the mret).
- mepc/mcause change only on trap entry; held otherwise.

## Timing
- Reset values: state S_RESET, reset_permission=1, trap_permission=0, all pulses 0, redirect_pc=0, mepc=0, mcause=`NO_E`, halt=0.
- All outputs registered except stall_f/flush_d in S_DRAIN, which decode state combinationally.
- E exception sampled at edge n:
  - redirect, flush_d/e, mepc, mcause and trap_permission are valid in cycle n+1.
  - redirect is high for exactly one cycle.
- F exception sampled at edge n, no interference: drain occupies cycles n+1..n+DRAIN_CYC; redirect occurs in cycle n+DRAIN_CYC+1.
- mret sampled at edge n: permission flag drops and redirect is asserted in cycle n+1.
- Async reset mid-drain or mid-trap: immediate return to reset values; pending cause is lost.

## Configuration
- TRAP_COUNTER_EN defined: adds port o_trap_count out 16, a count of trap entries that saturates at 16'hFFFF and resets to 0. HALT entries are not counted.
- Undefined: no port, no counter logic.

## Structure
- Constants.vh: state encodings (TC_S_*), region bases, reset-vector address. Exception codes already live there.
- One sub-module, trap_drain_counter: load/decrement/zero-flag counter used by S_DRAIN.

## Test plan
- Release reset, mret at pc_e=0x40010 → reset_permission 1→0, redirect_pc=0x80000 one cycle later, state S_RUN.
- In S_RUN, `E_LOAD_ACCESS_FAULT` at pc_e=0x80024 → next cycle redirect=1, mepc=0x80024, mcause=`E_LOAD_ACCESS_FAULT`, trap_permission=1. Later mret → redirect_pc=0x80028.
- `E_ILLEGAL_INSTR` on fetch at pc_f=0x80040 → 2 cycles stall_f/flush_d, then redirect with mepc=0x80040.
- Same F fault, with `E_STORE_ADDR_FAULT` at pc_e=0x80038 in drain cycle 1 → mepc=0x80038, mcause=store fault.
- F fault plus i_branch_taken_e during drain → no trap, back to S_RUN.
- `E_ECALL` while trap_permission=1 → o_halt=1 held until i_rst. Apply i_rst mid-halt → all reset values restored.
